// File: rtl/fp21_pack_pkg.sv
// Shared FP21 format constants and the result-class encoding used by the pack stage.
package fp21_pack_pkg;
  localparam int EXP_W_DEF  = 7;
  localparam int MAN_W_DEF  = 13;
  localparam int BIAS_DEF   = 63;
  localparam int EXP_MAX    = (1 << EXP_W_DEF) - 1;
  localparam int WORD_W     = 1 + EXP_W_DEF + MAN_W_DEF;

  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_OVF  = 2'd2,
    CLS_UNF  = 2'd3
  } cls_e;
endpackage

// File: rtl/fp21_lzc14.sv
// Combinational leading-zero counter; an all-zero input reports W.
module fp21_lzc14 #(
  parameter int W  = 14,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  in_bits,
  output logic [CW-1:0] lzc
);
  logic found;

  always_comb begin
    lzc   = CW'(W);
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found && in_bits[i]) begin
        lzc   = CW'(W - 1 - i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fp21_pack.sv
// FP21 pack stage: renormalize, bias, saturate/flush and pack, in a fixed
// 3-stage valid-qualified pipeline with sticky exception flags.
module fp21_pack
  import fp21_pack_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  parameter int BIAS  = BIAS_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_sign,
  input  logic [EXP_W:0]         in_exp,
  input  logic [MAN_W:0]         in_frac,
  input  logic                   clr_flags,
  output logic                   out_valid,
  output logic [EXP_W+MAN_W:0]   out_word,
  output logic                   ovf_flag,
  output logic                   unf_flag,
  output logic [15:0]            ovf_count
);
  localparam int FRAC_W = MAN_W + 1;
  localparam int LZC_W  = $clog2(FRAC_W + 1);
  localparam int BW     = EXP_W + 3;

  localparam logic [BW-1:0] BIAS_B = BW'(BIAS);
  localparam logic [BW-1:0] EMAX_B = BW'((1 << EXP_W) - 1);

  // Stage 1
  logic              s1_valid_q, s1_valid_d;
  logic              s1_sign_q,  s1_sign_d;
  logic              s1_zero_q,  s1_zero_d;
  logic [EXP_W:0]    s1_exp_q,   s1_exp_d;
  logic [MAN_W:0]    s1_frac_q,  s1_frac_d;
  logic [LZC_W-1:0]  s1_lzc_q,   s1_lzc_d;
  logic [LZC_W-1:0]  lzc_in;

  // Stage 2
  logic              s2_valid_q, s2_valid_d;
  logic              s2_sign_q,  s2_sign_d;
  logic              s2_zero_q,  s2_zero_d;
  logic [EXP_W+1:0]  s2_exp_q,   s2_exp_d;
  logic [MAN_W:0]    s2_frac_q,  s2_frac_d;

  // Stage 3 / outputs
  logic                  out_valid_q, out_valid_d;
  logic [EXP_W+MAN_W:0]  out_word_q,  out_word_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [15:0]           cnt_base;

  logic [BW-1:0]         biased;
  logic [EXP_W+MAN_W:0]  word;
  logic                  ev_ovf, ev_unf;
  cls_e                  cls;

  fp21_lzc14 #(.W(FRAC_W), .CW(LZC_W)) u_lzc (
    .in_bits (in_frac),
    .lzc     (lzc_in)
  );

  always_comb begin
    s1_valid_d = in_valid;
    s1_sign_d  = in_sign;
    s1_exp_d   = in_exp;
    s1_frac_d  = in_frac;
    s1_lzc_d   = lzc_in;
    s1_zero_d  = (in_frac == '0);
  end

  // exp_n is one bit wider than the input exponent, so subtracting lzc cannot wrap.
  always_comb begin
    s2_valid_d = s1_valid_q;
    s2_sign_d  = s1_sign_q;
    s2_zero_d  = s1_zero_q;
    s2_frac_d  = s1_frac_q << s1_lzc_q;
    s2_exp_d   = {s1_exp_q[EXP_W], s1_exp_q} - {{(EXP_W + 2 - LZC_W){1'b0}}, s1_lzc_q};
  end

  always_comb begin
    biased = {s2_exp_q[EXP_W+1], s2_exp_q} + BIAS_B;
    if (s2_zero_q)                              cls = CLS_ZERO;
    else if (!biased[BW-1] && biased >= EMAX_B) cls = CLS_OVF;
    else if (biased[BW-1] || biased == '0)      cls = CLS_UNF;
    else                                        cls = CLS_NORM;

    word = {s2_sign_q, {(EXP_W + MAN_W){1'b0}}};
    case (cls)
      CLS_OVF:  word = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      CLS_NORM: word = {s2_sign_q, biased[EXP_W-1:0], s2_frac_q[MAN_W-1:0]};
      default:  word = {s2_sign_q, {(EXP_W + MAN_W){1'b0}}};
    endcase

    ev_ovf = s2_valid_q && (cls == CLS_OVF);
    ev_unf = s2_valid_q && (cls == CLS_UNF);

    out_valid_d = s2_valid_q;
    out_word_d  = s2_valid_q ? word : out_word_q;

    // A clear and a retiring event in the same cycle resolve in favour of the event.
    ovf_d    = (clr_flags ? 1'b0 : ovf_q) | ev_ovf;
    unf_d    = (clr_flags ? 1'b0 : unf_q) | ev_unf;
    cnt_base = clr_flags ? 16'd0 : cnt_q;
    cnt_d    = (ev_ovf && cnt_base != 16'hFFFF) ? cnt_base + 16'd1 : cnt_base;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_frac_q   <= '0;
      s1_lzc_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_exp_q    <= '0;
      s2_frac_q   <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_zero_q   <= s1_zero_d;
      s1_exp_q    <= s1_exp_d;
      s1_frac_q   <= s1_frac_d;
      s1_lzc_q    <= s1_lzc_d;
      s2_valid_q  <= s2_valid_d;
      s2_sign_q   <= s2_sign_d;
      s2_zero_q   <= s2_zero_d;
      s2_exp_q    <= s2_exp_d;
      s2_frac_q   <= s2_frac_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign ovf_flag  = ovf_q;
  assign unf_flag  = unf_q;
  assign ovf_count = cnt_q;
endmodule

// File: tb/tb_fp21_pack.sv
// Scoreboard bench for fp21_pack: arithmetic reference model, expected-word queue
// and a monitor that checks every cycle one time unit after the rising edge.
module tb_fp21_pack;
  localparam int W = 21;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_sign;
  logic [7:0]    in_exp;
  logic [13:0]   in_frac;
  logic          clr_flags;
  logic          out_valid;
  logic [W-1:0]  out_word;
  logic          ovf_flag;
  logic          unf_flag;
  logic [15:0]   ovf_count;

  logic [W-1:0]  exp_q[$];
  logic [1:0]    ev_q[$];
  int            cyc_q[$];

  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;
  int            m_cnt = 0;

  fp21_pack dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_frac   (in_frac),
    .clr_flags (clr_flags),
    .out_valid (out_valid),
    .out_word  (out_word),
    .ovf_flag  (ovf_flag),
    .unf_flag  (unf_flag),
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  // Reference: normalize by doubling, bias, then classify with plain integers.
  function automatic void ref_pack(input logic s, input logic [7:0] e8, input logic [13:0] f,
                                   output logic [W-1:0] word, output logic [1:0] ev);
    int e, m, b;
    e = int'($signed(e8));
    m = int'(f);
    ev = 2'b00;
    if (m == 0) begin
      word = W'(s) << 20;
      return;
    end
    while (m < 8192) begin
      m = m * 2;
      e = e - 1;
    end
    b = e + 63;
    if (b >= 127) begin
      word = (W'(s) << 20) | (W'(127) << 13);
      ev = 2'b10;
    end else if (b <= 0) begin
      word = W'(s) << 20;
      ev = 2'b01;
    end else begin
      word = (W'(s) << 20) | (W'(b) << 13) | W'(m % 8192);
    end
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] e,
                       input logic [13:0] f, input logic clr, input logic r);
    logic [W-1:0] w;
    logic [1:0]   ev;
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    in_sign   = s;
    in_exp    = e;
    in_frac   = f;
    clr_flags = clr;
    if (v) begin
      ref_pack(s, e, f, w, ev);
      exp_q.push_back(w);
      ev_q.push_back(ev);
      cyc_q.push_back(cyc + 3);
    end
  endtask

  task automatic send(input logic s, input logic [7:0] e, input logic [13:0] f);
    drive(1'b1, s, e, f, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic clr);
    drive(1'b0, 1'b0, 8'h00, 14'h0000, clr, 1'b0);
  endtask

  // Monitor: samples rst/clr at the edge, checks outputs 1 time unit later.
  initial begin
    logic          r_s, c_s;
    logic [W-1:0]  w;
    logic [1:0]    ev;
    int            due;
    forever begin
      @(posedge clk);
      r_s = rst;
      c_s = clr_flags;
      cyc++;
      #1;
      if (r_s) begin
        exp_q.delete();
        ev_q.delete();
        cyc_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_cnt = 0;
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_out_word", longint'(out_word), 0);
      end else begin
        if (c_s) begin
          m_ovf = 1'b0;
          m_unf = 1'b0;
          m_cnt = 0;
        end
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out_valid", 1, 0);
          end else begin
            w   = exp_q.pop_front();
            ev  = ev_q.pop_front();
            due = cyc_q.pop_front();
            check("out_word", longint'(out_word), longint'(w));
            check("latency_cycle", longint'(cyc), longint'(due));
            if (ev[1]) begin
              m_ovf = 1'b1;
              if (m_cnt < 65535) m_cnt++;
            end
            if (ev[0]) m_unf = 1'b1;
          end
        end else if (cyc_q.size() != 0 && cyc_q[0] <= cyc) begin
          check("missing_out_valid", 0, 1);
          void'(exp_q.pop_front());
          void'(ev_q.pop_front());
          void'(cyc_q.pop_front());
        end
      end
      check("ovf_flag", longint'(ovf_flag), longint'(m_ovf));
      check("unf_flag", longint'(unf_flag), longint'(m_unf));
      check("ovf_count", longint'(ovf_count), longint'(m_cnt));
    end
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_frac = '0; clr_flags = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 14'h0000, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 14'h0000, 1'b0, 1'b1);
    idle(1'b0);

    // Directed: 1.0, -2.5 back to back, unnormalized, signed zero.
    send(1'b0, 8'd0, 14'h2000);
    send(1'b1, 8'd1, 14'h2800);
    send(1'b0, 8'd3, 14'h0800);
    send(1'b1, 8'd0, 14'h0000);
    send(1'b0, 8'h80, 14'h0001);
    repeat (4) idle(1'b0);

    // Overflow then underflow.
    send(1'b0, 8'd64, 14'h2000);
    send(1'b0, 8'hC1, 14'h2000);
    repeat (4) idle(1'b0);

    // Clear coincident with a retiring overflow, then a clear on its own.
    send(1'b1, 8'd70, 14'h3FFF);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // Three in flight, then reset; also an input coincident with reset.
    send(1'b0, 8'd64, 14'h2000);
    send(1'b0, 8'd2, 14'h1000);
    send(1'b0, 8'hC1, 14'h2000);
    drive(1'b1, 1'b0, 8'd5, 14'h2000, 1'b0, 1'b1);
    repeat (4) idle(1'b0);

    // Randomized traffic with bubbles and occasional clears.
    for (int i = 0; i < 600; i++) begin
      n = $urandom_range(0, 9);
      if (n < 7)
        drive(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
              14'($urandom_range(0, 16383) >> $urandom_range(0, 14)),
              ($urandom_range(0, 19) == 0), 1'b0);
      else
        idle($urandom_range(0, 9) == 0);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      idle(1'b0);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", longint'(exp_q.size()), 0);
    idle(1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
